// File: rtl/alarm_scheduler.sv
// Four-slot alarm clock scheduler.
// Each slot holds a wake-up time and an enable bit. Slots that match the
// current time on a second tick queue up as pending. A three-state session
// FSM (idle / ringing / snoozed) serves pending slots in slot-index order
// and drives the siren.
module alarm_scheduler #(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [7:0] current_hour,
  input  logic [7:0] current_minute,
  input  logic [7:0] current_second,
  input  logic       cfg_we,
  input  logic [1:0] cfg_slot,
  input  logic [7:0] cfg_hour,
  input  logic [7:0] cfg_minute,
  input  logic [7:0] cfg_second,
  input  logic       cfg_enable,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic       siren,
  output logic [1:0] active_slot,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] slot_enabled
);

  // The timeout counter saturates at RING_TIMEOUT, so it needs to hold that value.
  localparam int CNT_W = (RING_TIMEOUT < 1) ? 1 : $clog2(RING_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RING_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       pending_q, pending_d;
  logic [1:0]       active_slot_q, active_slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tgt_hour_q, tgt_hour_d;
  logic [7:0]       tgt_minute_q, tgt_minute_d;
  logic [7:0]       tgt_second_q, tgt_second_d;
  logic             siren_q, siren_d;

  logic [3:0]       slot_we;
  logic [3:0]       match;
  logic [3:0]       active_mask;
  logic [1:0]       lowest_idx;
  logic [7:0]       snz_min_sum;
  logic [7:0]       snz_minute;
  logic [7:0]       snz_hour;
  logic             at_target;

  // ---------------------------------------------------------------------
  // Per-slot storage and time comparison
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [7:0] hour_q, hour_d;
    logic [7:0] minute_q, minute_d;
    logic [7:0] second_q, second_d;
    logic       enable_q, enable_d;

    assign slot_we[gi] = cfg_we && (cfg_slot == 2'(gi));

    // A configuration write replaces every field of the slot at once.
    always_comb begin
      hour_d   = hour_q;
      minute_d = minute_q;
      second_d = second_q;
      enable_d = enable_q;
      if (slot_we[gi]) begin
        hour_d   = cfg_hour;
        minute_d = cfg_minute;
        second_d = cfg_second;
        enable_d = cfg_enable;
      end
    end

    // Slot registers; reset leaves the slot at 00:00:00 and disabled.
    always_ff @(posedge clk) begin
      if (rst) begin
        hour_q   <= '0;
        minute_q <= '0;
        second_q <= '0;
        enable_q <= 1'b0;
      end else begin
        hour_q   <= hour_d;
        minute_q <= minute_d;
        second_q <= second_d;
        enable_q <= enable_d;
      end
    end

    assign match[gi] = sec_tick && enable_q &&
                       (hour_q == current_hour) &&
                       (minute_q == current_minute) &&
                       (second_q == current_second);

    assign slot_enabled[gi] = enable_q;
  end

  // The slot owning the current session must not re-queue itself.
  assign active_mask = (state_q != ST_IDLE) ? (4'b0001 << active_slot_q) : 4'b0000;

  assign at_target = (current_hour == tgt_hour_q) &&
                     (current_minute == tgt_minute_q) &&
                     (current_second == tgt_second_q);

  // Pick the lowest-index pending slot (scan downward so the lowest wins).
  always_comb begin
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) lowest_idx = 2'(i);
    end
  end

  // Snooze target: now + SNOOZE_MIN minutes with minute and hour roll-over.
  always_comb begin
    snz_min_sum = current_minute + 8'(SNOOZE_MIN);
    snz_minute  = snz_min_sum;
    snz_hour    = current_hour;
    if (snz_min_sum >= 8'd60) begin
      snz_minute = snz_min_sum - 8'd60;
      snz_hour   = (current_hour >= 8'd23) ? 8'd0 : current_hour + 8'd1;
    end
  end

  // Session FSM next-state, pending queue and timeout counter.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | (match & ~active_mask);
    active_slot_d = active_slot_q;
    cnt_d         = cnt_q;
    tgt_hour_d    = tgt_hour_q;
    tgt_minute_d  = tgt_minute_q;
    tgt_second_d  = tgt_second_q;

    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          state_d                = ST_RINGING;
          active_slot_d          = lowest_idx;
          cnt_d                  = '0;
          pending_d[lowest_idx]  = 1'b0;
        end
      end
      ST_RINGING: begin
        if (btn_stop) begin
          state_d = ST_IDLE;
        end else if (btn_snooze) begin
          state_d      = ST_SNOOZE;
          tgt_hour_d   = snz_hour;
          tgt_minute_d = snz_minute;
          tgt_second_d = current_second;
        end else if (sec_tick) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) state_d = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (btn_stop) begin
          state_d = ST_IDLE;
        end else if (sec_tick && at_target) begin
          state_d = ST_RINGING;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Rewriting a slot discards anything it had queued; disabling the slot
    // that is currently ringing or snoozed ends its session.
    if (cfg_we) begin
      pending_d[cfg_slot] = 1'b0;
      if (!cfg_enable && (state_q != ST_IDLE) && (cfg_slot == active_slot_q)) begin
        state_d = ST_IDLE;
      end
    end
  end

  assign siren_d = (state_d == ST_RINGING);

  // Session state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      active_slot_q <= '0;
      cnt_q         <= '0;
      tgt_hour_q    <= '0;
      tgt_minute_q  <= '0;
      tgt_second_q  <= '0;
      siren_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      active_slot_q <= active_slot_d;
      cnt_q         <= cnt_d;
      tgt_hour_q    <= tgt_hour_d;
      tgt_minute_q  <= tgt_minute_d;
      tgt_second_q  <= tgt_second_d;
      siren_q       <= siren_d;
    end
  end

  assign siren       = siren_q;
  assign ringing     = (state_q == ST_RINGING);
  assign snoozing    = (state_q == ST_SNOOZE);
  assign active_slot = active_slot_q;

endmodule
